solve_sequencer: RTL and testbench
==================================

Name: solve_sequencer

Overview:
- Top-level controller for the Day 6 worksheet solver. Walks NUM_PROBLEMS problem records in a synchronous-read worksheet memory.
- Streams each problem's opcode and operands to an external reduce unit over a valid/ready handshake, collects the per-problem result and accumulates the grand total.
- Drives count/done, the outputs the top-level bench waits on. Starts automatically after reset release; no start input.

Parameters:
- NUM_PROBLEMS, 4, number of problem records (min 1).
- OPS_PER_PROB, 3, operands per problem (min 2).
- OPERAND_W, 16, operand width.
- ADDR_W, 12, worksheet memory address width.
- ACC_W, 64, result and total width.

Ports:
- clk  in  1  system clock; sole clock domain.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_W  read address.
- mem_rdata  in  OPERAND_W  read data, valid the cycle after mem_rd_en.
- op_valid  out  1  issue beat valid.
- op_ready  in  1  reduce unit accepts beat.
- op_first  out  1  first operand of a problem.
- op_last  out  1  last operand of a problem.
- op_code  out  1  0 = add, 1 = multiply.
- op_data  out  OPERAND_W  operand.
- res_valid  in  1  per-problem result valid (single-cycle pulse).
- res_data  in  ACC_W  per-problem result.
- busy  out  1  sequencing in progress.
- count  out  ACC_W  grand total.
- done  out  1  all problems summed.

Behaviour:
- Memory layout: problem p occupies words p*(OPS_PER_PROB+1) .. +OPS_PER_PROB. Word 0 is the opcode (bit0 only; upper bits ignored), followed by the operands.
- Reset values: all outputs 0; state INIT; problem index, operand index and total all 0.
- INIT: entered while rst=0. Moves to RD_OPC on the first clk edge with rst=1.
- RD_OPC: mem_rd_en=1, mem_addr=opcode word → LAT_OPC.
- LAT_OPC: latch mem_rdata[0] into op_code register → RD_ARG.
- RD_ARG: mem_rd_en=1, address of operand k → LAT_ARG.
- LAT_ARG: load op_data from mem_rdata and raise op_valid. Set op_first=(k==0) and op_last=(k==OPS_PER_PROB-1) → ISSUE.
- ISSUE: hold op_valid, op_data, op_first, op_last and op_code stable until op_valid&op_ready. On the handshake, drop op_valid next cycle; if not last, k++ → RD_ARG; if last → WAIT_RES.
- WAIT_RES: on res_valid, total <= total + res_data (mod 2^ACC_W), then:
  - last problem → DONE;
  - otherwise p++, k=0 → RD_OPC.
- res_valid outside WAIT_RES is ignored.
- DONE: done=1, busy=0, count stable. Terminal until reset.
- busy=1 in every state except INIT and DONE.
- count is a registered copy of total, updated the cycle after the accumulate.
- Throughput: best case 3 cycles per operand plus the reduce unit's latency. Performance is not a requirement.
- Reset mid-operation: all state clears asynchronously and op_valid drops immediately. After release, sequencing restarts from problem 0.

Optional Feature:
- SOLVE_SEQ_OVF_DETECT_EN defined: adds output port ovf (1 bit, reset 0). ovf sets sticky when the total addition carries out of ACC_W bits; cleared only by reset.
- Not defined: no ovf port; the total wraps silently.

Decomposition:
- Package solve_pkg:
  - FSM state enum (INIT, RD_OPC, LAT_OPC, RD_ARG, LAT_ARG, ISSUE, WAIT_RES, DONE);
  - OP_ADD=1'b0, OP_MUL=1'b1;
  - a function computing the record base address from p.
- One sub-module is natural: solve_addr_gen, which holds the p/k counters and produces mem_addr plus the last-problem and last-operand flags.

Test Plan:
- Example worksheet, 4 problems × 3 operands: {mul 123,45,6}, {add 328,64,98}, {mul 51,387,215}, {add 64,23,314}. Bench reduce model always ready, 2-cycle result latency → count=4277556, done=1, busy=0. Expected per-problem results: 33210, 490, 4243455, 401.
- Same data with op_ready randomly low (~50%) → same count=4277556. Check op_data, op_first, op_last and op_code never change while op_valid=1 and op_ready=0.
- Result delayed 20 cycles, plus a spurious res_valid pulse during ISSUE → spurious pulse ignored; count=4277556.
- Drive rst=0 in the middle of problem 2, then release → outputs 0 during reset; final count=4277556 (no double count).
- Opcode word 0xFFFE → treated as add. Single problem {add 1,2,3} with NUM_PROBLEMS=1 → count=6.
- With SOLVE_SEQ_OVF_DETECT_EN: reduce model returns 2^63 for each of 2 problems → count=0, ovf=1. Without the macro: count=0 and no ovf port.

Source files
------------

// File: rtl/solve_pkg.sv
// solve_pkg: shared FSM encoding, opcode values and record addressing for solve_sequencer.
package solve_pkg;
    typedef enum logic [2:0] {INIT, RD_OPC, LAT_OPC, RD_ARG, LAT_ARG, ISSUE, WAIT_RES, DONE} state_t;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;
    function automatic logic [31:0] rec_base(input logic [31:0] p, input logic [31:0] ops);
        return p * (ops + 32'd1);
    endfunction
endpackage

// File: rtl/solve_addr_gen.sv
// solve_addr_gen: problem/operand counters and worksheet read address for solve_sequencer.
module solve_addr_gen
    import solve_pkg::*;
#(
    parameter int NUM_PROBLEMS = 4,
    parameter int OPS_PER_PROB = 3,
    parameter int ADDR_W       = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_k_inc,
    input  logic              i_p_inc,
    input  logic              i_sel_arg,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_first_k,
    output logic              o_last_k,
    output logic              o_last_p
);
    localparam int PW = NUM_PROBLEMS > 1 ? $clog2(NUM_PROBLEMS) : 1;
    localparam int KW = $clog2(OPS_PER_PROB);
    logic [PW-1:0] r_p;
    logic [KW-1:0] r_k;
    logic [31:0]   w_base;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p <= '0;
            r_k <= '0;
        end else if (i_p_inc) begin
            r_p <= r_p + 1'b1;
            r_k <= '0;
        end else if (i_k_inc) begin
            r_k <= r_k + 1'b1;
        end
    end
    assign w_base    = rec_base(32'(r_p), 32'(OPS_PER_PROB));
    // operands follow the opcode word of each record
    assign o_addr    = ADDR_W'(i_sel_arg ? w_base + 32'd1 + 32'(r_k) : w_base);
    assign o_first_k = r_k == '0;
    assign o_last_k  = r_k == KW'(OPS_PER_PROB - 1);
    assign o_last_p  = r_p == PW'(NUM_PROBLEMS - 1);
endmodule

// File: rtl/solve_sequencer.sv
// solve_sequencer: walks worksheet records, streams operands to the reduce unit and sums results.
// Optional sticky carry-out flag on output ovf when SOLVE_SEQ_OVF_DETECT_EN is defined.
module solve_sequencer
    import solve_pkg::*;
#(
    parameter int NUM_PROBLEMS = 4,
    parameter int OPS_PER_PROB = 3,
    parameter int OPERAND_W    = 16,
    parameter int ADDR_W       = 12,
    parameter int ACC_W        = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [OPERAND_W-1:0] mem_rdata,
    output logic                 op_valid,
    input  logic                 op_ready,
    output logic                 op_first,
    output logic                 op_last,
    output logic                 op_code,
    output logic [OPERAND_W-1:0] op_data,
    input  logic                 res_valid,
    input  logic [ACC_W-1:0]     res_data,
    output logic                 busy,
    output logic [ACC_W-1:0]     count,
    output logic                 done
`ifdef SOLVE_SEQ_OVF_DETECT_EN
    ,
    output logic                 ovf
`endif
);
    state_t           r_state;
    logic [ACC_W-1:0] r_total;
    logic             w_first_k;
    logic             w_last_k;
    logic             w_last_p;
    logic             w_k_inc;
    logic             w_p_inc;
`ifdef SOLVE_SEQ_OVF_DETECT_EN
    logic [ACC_W:0]   w_sum;
    assign w_sum = {1'b0, r_total} + {1'b0, res_data};
`else
    logic [ACC_W-1:0] w_sum;
    assign w_sum = r_total + res_data;
`endif

    assign w_k_inc = r_state == ISSUE && op_ready && !w_last_k;
    assign w_p_inc = r_state == WAIT_RES && res_valid && !w_last_p;

    solve_addr_gen #(
        .NUM_PROBLEMS(NUM_PROBLEMS),
        .OPS_PER_PROB(OPS_PER_PROB),
        .ADDR_W      (ADDR_W)
    ) u_addr (
        .clk      (clk),
        .rst      (rst),
        .i_k_inc  (w_k_inc),
        .i_p_inc  (w_p_inc),
        .i_sel_arg(r_state == RD_ARG),
        .o_addr   (mem_addr),
        .o_first_k(w_first_k),
        .o_last_k (w_last_k),
        .o_last_p (w_last_p)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= INIT;
            r_total   <= '0;
            mem_rd_en <= 1'b0;
            op_valid  <= 1'b0;
            op_first  <= 1'b0;
            op_last   <= 1'b0;
            op_code   <= OP_ADD;
            op_data   <= '0;
            busy      <= 1'b0;
            count     <= '0;
            done      <= 1'b0;
`ifdef SOLVE_SEQ_OVF_DETECT_EN
            ovf       <= 1'b0;
`endif
        end else begin
            mem_rd_en <= 1'b0;
            count     <= r_total;
            case (r_state)
                INIT: begin
                    r_state   <= RD_OPC;
                    mem_rd_en <= 1'b1;
                    busy      <= 1'b1;
                end
                RD_OPC: r_state <= LAT_OPC;
                LAT_OPC: begin
                    op_code   <= mem_rdata[0] ? OP_MUL : OP_ADD;
                    r_state   <= RD_ARG;
                    mem_rd_en <= 1'b1;
                end
                RD_ARG: r_state <= LAT_ARG;
                LAT_ARG: begin
                    op_data  <= mem_rdata;
                    op_valid <= 1'b1;
                    op_first <= w_first_k;
                    op_last  <= w_last_k;
                    r_state  <= ISSUE;
                end
                ISSUE: if (op_ready) begin
                    op_valid  <= 1'b0;
                    r_state   <= w_last_k ? WAIT_RES : RD_ARG;
                    mem_rd_en <= !w_last_k;
                end
                WAIT_RES: if (res_valid) begin
                    r_total   <= w_sum[ACC_W-1:0];
`ifdef SOLVE_SEQ_OVF_DETECT_EN
                    ovf       <= ovf | w_sum[ACC_W];
`endif
                    r_state   <= w_last_p ? DONE : RD_OPC;
                    mem_rd_en <= !w_last_p;
                    busy      <= !w_last_p;
                    done      <= w_last_p;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_solve_sequencer.sv
// tb_solve_sequencer: directed table-driven bench for solve_sequencer with memory and reduce-unit models.
module tb_solve_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          checks = 0;
    int          errors = 0;

    logic        mem_rd_en, op_valid, op_first, op_last, op_code, busy, done;
    logic [11:0] mem_addr;
    logic [15:0] mem_rdata = '0;
    logic [15:0] op_data;
    logic        op_ready = 1'b0;
    logic        res_valid = 1'b0;
    logic [63:0] res_data = '0;
    logic [63:0] count;

    logic        mem_rd_en2, op_valid2, op_first2, op_last2, op_code2, busy2, done2;
    logic [11:0] mem_addr2;
    logic [15:0] mem_rdata2 = '0;
    logic [15:0] op_data2;
    logic        op_ready2 = 1'b0;
    logic        res_valid2 = 1'b0;
    logic [63:0] res_data2 = '0;
    logic [63:0] count2;
`ifdef SOLVE_SEQ_OVF_DETECT_EN
    logic        ovf, ovf2;
`endif

    always #5 clk = ~clk;

    solve_sequencer #(.NUM_PROBLEMS(4), .OPS_PER_PROB(3), .OPERAND_W(16), .ADDR_W(12), .ACC_W(64)) dut (
        .clk(clk), .rst(rst), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .op_valid(op_valid), .op_ready(op_ready), .op_first(op_first), .op_last(op_last),
        .op_code(op_code), .op_data(op_data), .res_valid(res_valid), .res_data(res_data),
        .busy(busy), .count(count), .done(done)
`ifdef SOLVE_SEQ_OVF_DETECT_EN
        , .ovf(ovf)
`endif
    );

    solve_sequencer #(.NUM_PROBLEMS(1), .OPS_PER_PROB(3), .OPERAND_W(16), .ADDR_W(12), .ACC_W(64)) dut2 (
        .clk(clk), .rst(rst), .mem_rd_en(mem_rd_en2), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2),
        .op_valid(op_valid2), .op_ready(op_ready2), .op_first(op_first2), .op_last(op_last2),
        .op_code(op_code2), .op_data(op_data2), .res_valid(res_valid2), .res_data(res_data2),
        .busy(busy2), .count(count2), .done(done2)
`ifdef SOLVE_SEQ_OVF_DETECT_EN
        , .ovf(ovf2)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // worksheet memories with one cycle read latency
    logic [15:0] mem [0:15];
    logic [15:0] mem2 [0:3];
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr[3:0]];
    always @(posedge clk) if (mem_rd_en2) mem_rdata2 <= mem2[mem_addr2[1:0]];

    // reduce-unit model for the 4-problem instance
    bit          cfg_rnd = 0;
    bit          cfg_ovf = 0;
    int          cfg_lat = 2;
    int          spur_left = 0;
    int          m_prob = 0;
    int          m_k = 0;
    int          m_cnt = 0;
    logic [63:0] m_acc = '0;
    logic [63:0] got_res [0:3];
    bit          h_pend = 0;
    logic [18:0] h_val = '0;

    always @(negedge clk) begin
        if (!rst) begin
            op_ready = 1'b0;
            res_valid = 1'b0;
            m_prob = 0;
            m_k = 0;
            m_cnt = 0;
            h_pend = 0;
        end else begin
            if (h_pend) chk("stall_hold", {op_valid, op_first, op_last, op_code, op_data}, {1'b1, h_val});
            res_valid = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    res_valid = 1'b1;
                    res_data = cfg_ovf ? 64'h8000_0000_0000_0000 : m_acc;
                end
            end else if (spur_left > 0 && op_valid) begin
                res_valid = 1'b1;
                res_data = 64'd999;
                spur_left--;
            end
            op_ready = cfg_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (op_valid && op_ready) begin
                chk("op_first", op_first, m_k == 0);
                chk("op_last", op_last, m_k == 2);
                m_acc = m_k == 0 ? 64'(op_data) : (op_code ? m_acc * 64'(op_data) : m_acc + 64'(op_data));
                m_k++;
                if (m_k == 3) begin
                    if (m_prob < 4) got_res[m_prob] = m_acc;
                    m_prob++;
                    m_k = 0;
                    m_cnt = cfg_lat;
                end
            end
            h_pend = op_valid && !op_ready;
            h_val = {op_first, op_last, op_code, op_data};
        end
    end

    // reduce-unit model for the single-problem instance: always ready, one cycle latency
    int          k2 = 0;
    bit          pend2 = 0;
    logic [63:0] acc2 = '0;
    always @(negedge clk) begin
        if (!rst) begin
            op_ready2 = 1'b0;
            res_valid2 = 1'b0;
            k2 = 0;
            pend2 = 0;
        end else begin
            res_valid2 = 1'b0;
            if (pend2) begin
                res_valid2 = 1'b1;
                res_data2 = acc2;
                pend2 = 0;
            end
            if (op_valid2 && op_ready2) begin
                acc2 = k2 == 0 ? 64'(op_data2) : (op_code2 ? acc2 * 64'(op_data2) : acc2 + 64'(op_data2));
                k2++;
                if (k2 == 3) begin
                    pend2 = 1;
                    k2 = 0;
                end
            end
            op_ready2 = 1'b1;
        end
    end

    typedef struct {
        bit          rnd;
        int          lat;
        int          spur;
        logic [15:0] opc1;
        bit          ovf_mode;
        logic [63:0] exp_count;
    } vec_t;

    vec_t        vecs [0:4];
    logic [63:0] exp_res [0:3];

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: done still 0 after %0d cycles, required 1", name, n);
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic check_final(input string name, input logic [63:0] exp_count, input bit exp_ovf);
        chk({name, "_count"}, count, exp_count);
        chk({name, "_done"}, done, 1'b1);
        chk({name, "_busy"}, busy, 1'b0);
        for (int i = 0; i < 4; i++) chk($sformatf("%s_res%0d", name, i), got_res[i], exp_res[i]);
`ifdef SOLVE_SEQ_OVF_DETECT_EN
        chk({name, "_ovf"}, ovf, exp_ovf);
`else
        if (exp_ovf) chk({name, "_wrap"}, count, 64'd0);
`endif
    endtask

    task automatic start_run(input vec_t v);
        @(negedge clk);
        rst = 1'b0;
        cfg_rnd = v.rnd;
        cfg_lat = v.lat;
        spur_left = v.spur;
        cfg_ovf = v.ovf_mode;
        mem[4] = v.opc1;
        for (int i = 0; i < 4; i++) got_res[i] = '1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ctl", 64'({mem_rd_en, mem_addr, op_valid, op_first, op_last, op_code, op_data, busy, done}), 64'd0);
        chk("rst_count", count, 64'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [15:0] ws [0:15];
        int          n;
        ws = '{16'd1, 16'd123, 16'd45, 16'd6, 16'd0, 16'd328, 16'd64, 16'd98,
               16'd1, 16'd51, 16'd387, 16'd215, 16'd0, 16'd64, 16'd23, 16'd314};
        for (int i = 0; i < 16; i++) mem[i] = ws[i];
        mem2[0] = 16'hFFFE;
        mem2[1] = 16'd1;
        mem2[2] = 16'd2;
        mem2[3] = 16'd3;
        exp_res = '{64'd33210, 64'd490, 64'd4243455, 64'd401};
        vecs[0] = '{rnd: 0, lat: 2,  spur: 0, opc1: 16'h0000, ovf_mode: 0, exp_count: 64'd4277556};
        vecs[1] = '{rnd: 1, lat: 2,  spur: 0, opc1: 16'h0000, ovf_mode: 0, exp_count: 64'd4277556};
        vecs[2] = '{rnd: 0, lat: 20, spur: 3, opc1: 16'h0000, ovf_mode: 0, exp_count: 64'd4277556};
        vecs[3] = '{rnd: 1, lat: 2,  spur: 0, opc1: 16'hFFFE, ovf_mode: 0, exp_count: 64'd4277556};
        vecs[4] = '{rnd: 0, lat: 1,  spur: 0, opc1: 16'h0000, ovf_mode: 1, exp_count: 64'd0};

        for (int v = 0; v < 5; v++) begin
            start_run(vecs[v]);
            wait_done($sformatf("vec%0d", v));
            check_final($sformatf("vec%0d", v), vecs[v].exp_count, vecs[v].ovf_mode);
        end

        // reset while problem index 2 is issuing, then a clean rerun
        start_run(vecs[1]);
        n = 0;
        while (!(m_prob == 2 && op_valid) && n < 5000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("midrst_reached", 64'(m_prob == 2 && op_valid), 64'd1);
        rst = 1'b0;
        #1;
        chk("midrst_ctl", 64'({mem_rd_en, mem_addr, op_valid, op_first, op_last, op_code, op_data, busy, done}), 64'd0);
        chk("midrst_count", count, 64'd0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) got_res[i] = '1;
        rst = 1'b1;
        wait_done("midrst");
        check_final("midrst", 64'd4277556, 1'b0);

        chk("single_count", count2, 64'd6);
        chk("single_done", done2, 1'b1);
        chk("single_busy", busy2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
